// File: rtl/pir_alarm_ctrl_n.sv
// N-channel PIR motion alarm controller: per-channel debounce, armed/alarm/cooldown FSM,
// buzzer timeout, sticky trigger LEDs and peak/last/event statistics for the display path.
module pir_alarm_ctrl_n #(
    parameter int unsigned NUM_SENSORS = 3,
    parameter int unsigned DATA_W      = 7,
    parameter int unsigned THRESHOLD   = 50,
    parameter int unsigned DEBOUNCE    = 2,
    parameter int unsigned BUZZ_CYCLES = 100,
    parameter int unsigned HOLDOFF     = 16,
    parameter int unsigned EVT_W       = 8,
    localparam int unsigned ID_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arm,
    input  logic                          stop_alarm,
    input  logic                          clear_stats,
    input  logic [NUM_SENSORS*DATA_W-1:0] pir_data,
    output logic [NUM_SENSORS-1:0]        led,
    output logic                          buzzer,
    output logic [1:0]                    state,
    output logic [DATA_W-1:0]             peak_value,
    output logic [ID_W-1:0]               peak_id,
    output logic [DATA_W-1:0]             last_value,
    output logic [ID_W-1:0]               last_id,
    output logic [EVT_W-1:0]              event_count
);

    localparam int unsigned CNT_W   = $clog2(DEBOUNCE + 1);
    localparam int unsigned TMR_MAX = (BUZZ_CYCLES > HOLDOFF) ? BUZZ_CYCLES : HOLDOFF;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        StDisarmed = 2'd0,
        StArmed    = 2'd1,
        StAlarm    = 2'd2,
        StCooldown = 2'd3
    } state_e;

    logic [DATA_W-1:0]      ch_val [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] above;
    logic [NUM_SENSORS-1:0] trig;
    logic                   any_trig;
    logic [CNT_W-1:0]       cnt_q [NUM_SENSORS];

    logic [ID_W-1:0]        first_id;
    logic [DATA_W-1:0]      first_val;
    logic [ID_W-1:0]        max_id;
    logic [DATA_W-1:0]      max_val;
    logic                   alarm_exit;

    state_e                 state_q;
    logic [TMR_W-1:0]       tmr_q;
    logic [NUM_SENSORS-1:0] led_q;
    logic                   buzzer_q;
    logic [DATA_W-1:0]      peak_value_q;
    logic [ID_W-1:0]        peak_id_q;
    logic [DATA_W-1:0]      last_value_q;
    logic [ID_W-1:0]        last_id_q;
    logic [EVT_W-1:0]       evt_q;

    always_comb begin
        for (int i = 0; i < int'(NUM_SENSORS); i++) begin
            ch_val[i] = pir_data[i*DATA_W +: DATA_W];
            above[i]  = 32'(ch_val[i]) >= THRESHOLD;
            trig[i]   = cnt_q[i] == CNT_W'(DEBOUNCE);
        end
    end

    assign any_trig = |trig;

    // Debounce counters run in every state so a held input triggers immediately on arming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_SENSORS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_SENSORS); i++) begin
                if (!above[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] != CNT_W'(DEBOUNCE)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Lowest-index trigger feeds last_*; max value with lowest-index tie-break feeds peak_*.
    always_comb begin
        logic found;
        found     = 1'b0;
        first_id  = '0;
        first_val = '0;
        max_id    = '0;
        max_val   = '0;
        for (int i = int'(NUM_SENSORS) - 1; i >= 0; i--) begin
            if (trig[i]) begin
                first_id  = ID_W'(i);
                first_val = ch_val[i];
            end
        end
        for (int i = 0; i < int'(NUM_SENSORS); i++) begin
            if (trig[i] && (!found || ch_val[i] > max_val)) begin
                found   = 1'b1;
                max_id  = ID_W'(i);
                max_val = ch_val[i];
            end
        end
    end

    assign alarm_exit = (state_q == StAlarm) &&
                        (!arm || stop_alarm || tmr_q == TMR_W'(BUZZ_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StDisarmed;
            tmr_q        <= '0;
            led_q        <= '0;
            buzzer_q     <= 1'b0;
            peak_value_q <= '0;
            peak_id_q    <= '0;
            last_value_q <= '0;
            last_id_q    <= '0;
            evt_q        <= '0;
        end else begin
            unique case (state_q)
                StDisarmed: begin
                    if (arm) begin
                        state_q <= StArmed;
                    end
                end
                StArmed: begin
                    if (!arm) begin
                        state_q <= StDisarmed;
                    end else if (any_trig) begin
                        state_q  <= StAlarm;
                        buzzer_q <= 1'b1;
                        tmr_q    <= '0;
                    end
                end
                StAlarm: begin
                    led_q <= led_q | trig;
                    tmr_q <= tmr_q + TMR_W'(1);
                    if (!arm) begin
                        state_q <= StDisarmed;
                    end else if (alarm_exit) begin
                        state_q <= StCooldown;
                    end
                    if (alarm_exit) begin
                        led_q    <= '0;
                        buzzer_q <= 1'b0;
                        tmr_q    <= '0;
                    end
                end
                StCooldown: begin
                    tmr_q <= tmr_q + TMR_W'(1);
                    if (!arm) begin
                        state_q <= StDisarmed;
                        tmr_q   <= '0;
                    end else if (tmr_q == TMR_W'(HOLDOFF - 1)) begin
                        state_q <= StArmed;
                        tmr_q   <= '0;
                    end
                end
            endcase

            if (state_q == StAlarm && any_trig) begin
                last_value_q <= first_val;
                last_id_q    <= first_id;
                if (max_val > peak_value_q) begin
                    peak_value_q <= max_val;
                    peak_id_q    <= max_id;
                end
            end

            if (alarm_exit && evt_q != '1) begin
                evt_q <= evt_q + EVT_W'(1);
            end

            // Clearing wins over any same-cycle statistic update or event increment.
            if (clear_stats) begin
                peak_value_q <= '0;
                peak_id_q    <= '0;
                last_value_q <= '0;
                last_id_q    <= '0;
                evt_q        <= '0;
            end
        end
    end

    assign led         = led_q;
    assign buzzer      = buzzer_q;
    assign state       = state_q;
    assign peak_value  = peak_value_q;
    assign peak_id     = peak_id_q;
    assign last_value  = last_value_q;
    assign last_id     = last_id_q;
    assign event_count = evt_q;

endmodule

// File: tb/tb_pir_alarm_ctrl_n.sv
// Bench for pir_alarm_ctrl_n: table vectors, corner-case sequences and random stimulus
// checked every cycle against a cycle-level behavioural model.
module tb_pir_alarm_ctrl_n;

    localparam int N    = 3;
    localparam int DW   = 7;
    localparam int TH   = 50;
    localparam int DEB  = 2;
    localparam int BUZZ = 100;
    localparam int HOLD = 16;
    localparam int EW   = 2;
    localparam int IW   = 2;
    localparam int EVT_MAX = (1 << EW) - 1;

    logic            clk;
    logic            rst_n;
    logic            arm;
    logic            stop_alarm;
    logic            clear_stats;
    logic [N*DW-1:0] pir_data;
    logic [N-1:0]    led;
    logic            buzzer;
    logic [1:0]      state;
    logic [DW-1:0]   peak_value;
    logic [IW-1:0]   peak_id;
    logic [DW-1:0]   last_value;
    logic [IW-1:0]   last_id;
    logic [EW-1:0]   event_count;

    logic [DW-1:0]   d [N];

    int n_total = 0;
    int n_bad   = 0;

    pir_alarm_ctrl_n #(
        .NUM_SENSORS(N), .DATA_W(DW), .THRESHOLD(TH), .DEBOUNCE(DEB),
        .BUZZ_CYCLES(BUZZ), .HOLDOFF(HOLD), .EVT_W(EW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .stop_alarm(stop_alarm),
        .clear_stats(clear_stats), .pir_data(pir_data), .led(led), .buzzer(buzzer),
        .state(state), .peak_value(peak_value), .peak_id(peak_id),
        .last_value(last_value), .last_id(last_id), .event_count(event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) pir_data[i*DW +: DW] = d[i];
    end

    // Behavioural model: run lengths above threshold, mode number, cycles spent in mode.
    int       m_st, m_tmr;
    int       run [N];
    bit [N-1:0] m_led;
    int       m_pkv, m_pkid, m_lv, m_lid, m_evt;

    task automatic model_reset();
        m_st = 0; m_tmr = 0; m_led = '0;
        m_pkv = 0; m_pkid = 0; m_lv = 0; m_lid = 0; m_evt = 0;
        for (int i = 0; i < N; i++) run[i] = 0;
    endtask

    task automatic model_step();
        bit [N-1:0] tr;
        int nst, fid, mid, mv;
        fid = -1; mid = -1; mv = -1;
        for (int i = 0; i < N; i++) begin
            tr[i] = run[i] >= DEB;
            if (tr[i]) begin
                if (fid < 0) fid = i;
                if (int'(d[i]) > mv) begin mv = int'(d[i]); mid = i; end
            end
        end
        nst = m_st;
        case (m_st)
            0: if (arm) nst = 1;
            1: if (!arm) nst = 0; else if (tr != 0) nst = 2;
            2: begin
                m_led |= tr;
                if (!arm) nst = 0;
                else if (stop_alarm || m_tmr == BUZZ - 1) nst = 3;
                if (tr != 0) begin
                    m_lv = int'(d[fid]); m_lid = fid;
                    if (mv > m_pkv) begin m_pkv = mv; m_pkid = mid; end
                end
                if (nst != 2) begin
                    m_led = '0;
                    if (m_evt < EVT_MAX) m_evt++;
                end
            end
            default: if (!arm) nst = 0; else if (m_tmr == HOLD - 1) nst = 1;
        endcase
        m_tmr = (nst != m_st) ? 0 : m_tmr + 1;
        m_st  = nst;
        if (clear_stats) begin
            m_pkv = 0; m_pkid = 0; m_lv = 0; m_lid = 0; m_evt = 0;
        end
        for (int i = 0; i < N; i++) run[i] = (int'(d[i]) >= TH) ? ((run[i] < 1000) ? run[i] + 1 : run[i]) : 0;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [63:0] got, exp;
        got = 64'({state, buzzer, led, peak_value, peak_id, last_value, last_id, event_count});
        exp = 64'({2'(m_st), (m_st == 2), m_led, DW'(m_pkv), IW'(m_pkid), DW'(m_lv),
                   IW'(m_lid), EW'(m_evt)});
        chk("model", got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic drive(input logic a, input logic s, input logic c,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        arm = a; stop_alarm = s; clear_stats = c;
        d[0] = d0; d[1] = d1; d[2] = d2;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #10;
        rst_n = 1'b1;
    endtask

    task automatic wait_state(input logic [1:0] tgt, input int max, input string name);
        int n = 0;
        while (state !== tgt && n < max) begin
            step();
            n++;
        end
        chk(name, 64'(state), 64'(tgt));
    endtask

    typedef struct {
        logic          arm, stop, clr;
        logic [DW-1:0] d0, d1, d2;
        logic [1:0]    st;
        logic          bz;
        logic [N-1:0]  led;
        logic [EW-1:0] evt;
        logic [DW-1:0] pk;
    } vec_t;

    function automatic vec_t mk(logic a, logic s, logic c, logic [DW-1:0] d0,
                                logic [DW-1:0] d1, logic [DW-1:0] d2, logic [1:0] st,
                                logic bz, logic [N-1:0] l, logic [EW-1:0] e, logic [DW-1:0] pk);
        vec_t v;
        v.arm = a; v.stop = s; v.clr = c; v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.st = st; v.bz = bz; v.led = l; v.evt = e; v.pk = pk;
        return v;
    endfunction

    vec_t tbl [12];

    initial begin
        int n;
        tbl[0]  = mk(1, 0, 0,  0,  0, 0, 1, 0, 3'b000, 0,  0);
        tbl[1]  = mk(1, 0, 0, 90,  0, 0, 1, 0, 3'b000, 0,  0);  // one-cycle glitch
        tbl[2]  = mk(1, 0, 0, 10,  0, 0, 1, 0, 3'b000, 0,  0);
        tbl[3]  = mk(1, 0, 0,  0,  0, 0, 1, 0, 3'b000, 0,  0);
        tbl[4]  = mk(1, 0, 0,  0, 60, 0, 1, 0, 3'b000, 0,  0);
        tbl[5]  = mk(1, 0, 0,  0, 60, 0, 1, 0, 3'b000, 0,  0);
        tbl[6]  = mk(1, 0, 0,  0, 60, 0, 2, 1, 3'b000, 0,  0);
        tbl[7]  = mk(1, 0, 0,  0, 60, 0, 2, 1, 3'b010, 0, 60);
        tbl[8]  = mk(1, 1, 0,  0, 60, 0, 3, 0, 3'b000, 1, 60);
        tbl[9]  = mk(1, 0, 0,  0, 10, 0, 3, 0, 3'b000, 1, 60);
        tbl[10] = mk(0, 0, 0,  0,  0, 0, 0, 0, 3'b000, 1, 60);
        tbl[11] = mk(0, 0, 1,  0,  0, 0, 0, 0, 3'b000, 0,  0);

        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #12;
        chk("reset_outputs", 64'({state, buzzer, led, peak_value, peak_id, last_value, last_id,
                                  event_count}), 64'(0));
        rst_n = 1'b1;

        for (int k = 0; k < 12; k++) begin
            drive(tbl[k].arm, tbl[k].stop, tbl[k].clr, tbl[k].d0, tbl[k].d1, tbl[k].d2);
            step();
            chk($sformatf("vec%0d", k), 64'({state, buzzer, led, event_count, peak_value}),
                64'({tbl[k].st, tbl[k].bz, tbl[k].led, tbl[k].evt, tbl[k].pk}));
        end

        // Unattended alarm: buzzer exactly BUZZ cycles, then HOLD cycles of cooldown.
        do_reset();
        drive(1, 0, 0, 60, 0, 0);
        wait_state(2'd2, 10, "t3_enter_alarm");
        d[0] = 0;
        n = 0;
        while (buzzer === 1'b1 && n < 300) begin n++; step(); end
        chk("t3_buzz_cycles", 64'(n), 64'(BUZZ));
        chk("t3_cooldown", 64'(state), 64'(3));
        n = 0;
        while (state === 2'd3 && n < 100) begin n++; step(); end
        chk("t3_holdoff_cycles", 64'(n), 64'(HOLD));
        chk("t3_rearmed", 64'({state, event_count}), 64'({2'd1, 2'd1}));

        // Simultaneous triggers: tie goes to lowest index, later higher reading takes peak.
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 70, 0, 70);
        step(); step(); step();
        chk("t4_alarm", 64'(state), 64'(2));
        step();
        chk("t4_peak_tie", 64'({peak_value, peak_id, last_value, last_id}),
            64'({7'd70, 2'd0, 7'd70, 2'd0}));
        d[2] = 80;
        step();
        chk("t4_peak_new", 64'({peak_value, peak_id, last_value, last_id, led}),
            64'({7'd80, 2'd2, 7'd70, 2'd0, 3'b101}));
        stop_alarm = 1'b1;
        step();
        stop_alarm = 1'b0;
        chk("t4_stop", 64'({state, buzzer, led}), 64'({2'd3, 1'b0, 3'b000}));

        // Disarm mid-alarm counts an event; clear on the exit cycle wins.
        do_reset();
        drive(1, 0, 0, 0, 60, 0);
        wait_state(2'd2, 10, "t5_enter_alarm");
        step();
        arm = 1'b0;
        step();
        chk("t5_disarm", 64'({state, buzzer, event_count}), 64'({2'd0, 1'b0, 2'd1}));
        arm = 1'b1;
        wait_state(2'd2, 10, "t5_reenter");
        arm = 1'b0; clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        chk("t5_clear_on_exit", 64'({state, event_count, peak_value}), 64'(0));

        // Saturating event counter, then async reset mid-alarm.
        do_reset();
        drive(1, 0, 0, 0, 60, 0);
        for (int k = 0; k < 5; k++) begin
            wait_state(2'd2, 40, "t6_alarm");
            stop_alarm = 1'b1;
            step();
            stop_alarm = 1'b0;
        end
        chk("t6_saturate", 64'(event_count), 64'(EVT_MAX));
        wait_state(2'd2, 40, "t6_last_alarm");
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset", 64'({state, buzzer, led, peak_value, last_value, event_count}),
            64'(0));
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        #3;
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            arm         = ($urandom_range(0, 31) != 0);
            stop_alarm  = ($urandom_range(0, 24) == 0);
            clear_stats = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) d[i] = DW'($urandom_range(0, 127));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
